// File: rtl/aes_tb_pkg.sv
// aes_tb_pkg: shared FSM states, default seeds, latency and LFSR taps for the AES stimulus sequencer.
package aes_tb_pkg;
  typedef enum logic [2:0] {IDLE, SEED, RUN, DRAIN, DONE} state_t;
  localparam logic [127:0] STATE_SEED_DEFAULT = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] KEY_SEED_DEFAULT = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED;
  localparam int AES_LATENCY_DEFAULT = 21;
  // One-based tap positions of the 128-bit XNOR LFSR
  localparam int TAP0 = 128;
  localparam int TAP1 = 126;
  localparam int TAP2 = 101;
  localparam int TAP3 = 99;
endpackage

// File: rtl/lfsr.sv
// lfsr: left-shifting XNOR LFSR with seed load; feedback enters bit 0.
module lfsr
  import aes_tb_pkg::*;
#(
  parameter int NUM_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                seed_dv,
  input  logic [NUM_BITS-1:0] seed,
  output logic [NUM_BITS-1:0] data
);
  logic fb;
  assign fb = ~(data[TAP0-1] ^ data[TAP1-1] ^ data[TAP2-1] ^ data[TAP3-1]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data <= '0;
    else if (enable) data <= seed_dv ? seed : {data[NUM_BITS-2:0], fb};
endmodule

// File: rtl/aes_stim_sequencer.sv
// aes_stim_sequencer: drives aes_128 from two LFSRs and folds the pipelined ciphertexts into a signature.
module aes_stim_sequencer
  import aes_tb_pkg::*;
#(
  parameter int                  NUM_BITS    = 128,
  parameter int                  AES_LATENCY = AES_LATENCY_DEFAULT,
  parameter int                  CNT_W       = 32,
  parameter logic [NUM_BITS-1:0] STATE_SEED  = STATE_SEED_DEFAULT,
  parameter logic [NUM_BITS-1:0] KEY_SEED    = KEY_SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_tests,
  output logic [NUM_BITS-1:0] aes_state,
  output logic [NUM_BITS-1:0] aes_key,
  input  logic [NUM_BITS-1:0] aes_out,
  output logic                busy,
  output logic                out_valid,
  output logic                done,
  output logic [NUM_BITS-1:0] signature,
  output logic [CNT_W-1:0]    issued_cnt,
  output logic [CNT_W-1:0]    checked_cnt
);
  state_t                 state, next;
  logic [CNT_W-1:0]       n_tests;
  logic [AES_LATENCY-1:0] vld_line;
  logic [CNT_W-1:0]       issued_inc, checked_inc;
  logic                   issue, accept, seeding;
  assign issue       = state == RUN;
  assign seeding     = state == SEED;
  assign accept      = start && (state == IDLE || state == DONE);
  assign busy        = seeding || issue || state == DRAIN;
  assign done        = state == DONE;
  assign out_valid   = vld_line[AES_LATENCY-1];
  assign issued_inc  = &issued_cnt ? issued_cnt : issued_cnt + 1'b1;
  assign checked_inc = &checked_cnt ? checked_cnt : checked_cnt + 1'b1;
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: next = accept ? (num_tests == '0 ? DONE : SEED) : state;
      SEED:       next = RUN;
      RUN:        next = issued_inc == n_tests ? DRAIN : RUN;
      DRAIN:      next = out_valid && checked_inc == n_tests ? DONE : DRAIN;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      n_tests     <= '0;
      vld_line    <= '0;
      signature   <= '0;
      issued_cnt  <= '0;
      checked_cnt <= '0;
    end else begin
      state    <= next;
      vld_line <= (vld_line << 1) | AES_LATENCY'(issue);
      if (accept) begin
        n_tests     <= num_tests;
        signature   <= '0;
        issued_cnt  <= '0;
        checked_cnt <= '0;
      end else begin
        if (issue) issued_cnt <= issued_inc;
        if (out_valid) begin
          signature   <= {signature[NUM_BITS-2:0], signature[NUM_BITS-1]} ^ aes_out;
          checked_cnt <= checked_inc;
        end
      end
    end
  lfsr #(.NUM_BITS(NUM_BITS)) u_state_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (seeding || issue),
    .seed_dv(seeding),
    .seed   (STATE_SEED),
    .data   (aes_state)
  );
  lfsr #(.NUM_BITS(NUM_BITS)) u_key_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (seeding || issue),
    .seed_dv(seeding),
    .seed   (KEY_SEED),
    .data   (aes_key)
  );
endmodule
